qracc_sram_arbiter: RTL
=======================

# qracc_sram_arbiter

Parametrised N-master to one-slave arbiter for the QRAcc SRAM request/response port. It merges several request-side masters (controller, feature loader, debug/CSR path) onto a single SRAM macro port using the rq_valid/rq_ready/rd_valid protocol. It tracks outstanding reads in an ID FIFO so each read response returns to the master that issued it. It sits between the qracc controller's SRAM clients and the column/bank SRAM wrapper.

## Interface
- numMasters, 2: number of requesting masters (≥2).
- numRows, 128: SRAM rows; address width AW = $clog2(numRows).
- numCols, 32: data width DW.
- maxOutstanding, 4: depth of the read-ID FIFO (power of 2, ≥2).
- arbMode, 0: 0 = round-robin, 1 = fixed priority (master 0 highest).

- clk  input  1  clock; all state on rising edge.
- nrst  input  1  asynchronous active-low reset.
- m_rq_wr_i  input  numMasters  per-master write (1) / read (0).
- m_rq_valid_i  input  numMasters  per-master request valid.
- m_rq_ready_o  output  numMasters  per-master request accepted.
- m_wr_data_i  input  numMasters*DW  flattened write data, master m at [m*DW +: DW].
- m_addr_i  input  numMasters*AW  flattened address.
- m_rd_valid_o  output  numMasters  read response valid, one-hot or zero.
- m_rd_data_o  output  DW  read data, shared across masters, qualified by m_rd_valid_o.
- s_rq_wr_o  output  1  slave write/read.
- s_rq_valid_o  output  1  slave request valid.
- s_rq_ready_i  input  1  slave accepts request.
- s_wr_data_o  output  DW  slave write data.
- s_addr_o  output  AW  slave address.
- s_rd_valid_i  input  1  slave read data valid.
- s_rd_data_i  input  DW  slave read data.
- err_o  output  1  sticky protocol error flag.
- outstanding_o  output  $clog2(maxOutstanding)+1  current read-ID FIFO occupancy.

## Operation
- Eligible master: m_rq_valid_i[m] && (m_rq_wr_i[m] || !fifo_full). Writes are never blocked by the FIFO state.
- Grant (combinational): in round-robin mode, the first eligible master at or after rr_ptr, searching upward mod numMasters. In fixed mode, the lowest-index eligible master.
- s_rq_valid_o = any eligible. s_rq_wr_o, s_wr_data_o and s_addr_o are muxed from the granted master. When there is no grant, they are driven to 0.
- m_rq_ready_o[g] = grant[g] && s_rq_ready_i. All other bits are 0. No combinational path exists from m_rq_ready_o to m_rq_valid_i.
- Handshake = s_rq_valid_o && s_rq_ready_i.
  - On a read handshake, push granted index g into the ID FIFO.
  - On any handshake in round-robin mode, rr_ptr <= (g+1) mod numMasters.
  - rr_ptr does not move without a handshake.
- Response: on s_rd_valid_i with FIFO non-empty, pop the head ID h. Next cycle, m_rd_valid_o = one-hot(h) and m_rd_data_o = s_rd_data_i (registered).
- s_rd_valid_i with FIFO empty: no pop, no response, err_o <= 1. err_o stays set until reset.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
  - fifo_full is evaluated on the registered occupancy, before the pop. A read is therefore blocked in a cycle where the FIFO is full even if a pop occurs (conservative, no bypass).
- FIFO pointers wrap mod maxOutstanding. Occupancy range is 0..maxOutstanding.

## Timing
- Request path: zero added latency; slave sees the request in the same cycle as the master.
- Response path: exactly 1 cycle from s_rd_valid_i to m_rd_valid_o. Back-to-back responses are supported at 1 per cycle.
- Reset values: m_rd_valid_o=0, m_rd_data_o=0, err_o=0, outstanding_o=0, rr_ptr=0, FIFO empty.
  - Combinational outputs follow the inputs once state is reset.
- Reset mid-operation: all in-flight IDs are discarded. Slave responses arriving after reset release with an empty FIFO set err_o.
- A master holding m_rq_valid_i while not granted must keep its request stable. The arbiter does not latch requests.

## Test plan
- Round-robin fairness: numMasters=2, both masters issue continuous writes with s_rq_ready_i=1 -> grants alternate 0,1,0,1. Each master gets 4 handshakes in 8 cycles.
- Fixed priority: arbMode=1, masters 0 and 1 both valid for 3 cycles -> master 0 granted all 3 cycles. Master 1 is granted in cycle 4 after master 0 drops valid.
- Read routing: master 1 reads addr 5, then master 0 reads addr 9. Slave returns 0xAAAA0005, then 0xBBBB0009 on consecutive cycles -> m_rd_valid_o=2'b10 with data 0xAAAA0005, then 2'b01 with data 0xBBBB0009, each 1 cycle after s_rd_valid_i.
- FIFO full: maxOutstanding=4, 4 reads accepted with no responses -> outstanding_o=4. A 5th read sees m_rq_ready_o=0, while a concurrent write from the other master is still accepted. After one response, the read is accepted the following cycle.
- Slave stall: s_rq_ready_i=0 for 5 cycles with master 0 valid -> no handshake, rr_ptr unchanged, no FIFO push. The request completes on the first cycle s_rq_ready_i=1.
- Error and reset: s_rd_valid_i with FIFO empty -> err_o=1 next cycle and no m_rd_valid_o. Asserting nrst mid-stream with 2 reads outstanding -> outstanding_o=0, err_o=0, all m_rd_valid_o=0 immediately.

Source files
------------

// File: rtl/qracc_sram_arbiter.sv
// N-master to one-slave arbiter for the QRAcc SRAM request/response port.
// Read IDs are queued in a FIFO so each response returns to its issuing master.
module qracc_sram_arbiter #(
  parameter int numMasters     = 2,
  parameter int numRows        = 128,
  parameter int numCols        = 32,
  parameter int maxOutstanding = 4,
  parameter int arbMode        = 0
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic [numMasters-1:0]                       m_rq_wr_i,
  input  logic [numMasters-1:0]                       m_rq_valid_i,
  output logic [numMasters-1:0]                       m_rq_ready_o,
  input  logic [numMasters*numCols-1:0]               m_wr_data_i,
  input  logic [numMasters*$clog2(numRows)-1:0]       m_addr_i,
  output logic [numMasters-1:0]                       m_rd_valid_o,
  output logic [numCols-1:0]                          m_rd_data_o,
  output logic                                        s_rq_wr_o,
  output logic                                        s_rq_valid_o,
  input  logic                                        s_rq_ready_i,
  output logic [numCols-1:0]                          s_wr_data_o,
  output logic [$clog2(numRows)-1:0]                  s_addr_o,
  input  logic                                        s_rd_valid_i,
  input  logic [numCols-1:0]                          s_rd_data_i,
  output logic                                        err_o,
  output logic [$clog2(maxOutstanding):0]             outstanding_o
);

  localparam int AW = $clog2(numRows);
  localparam int DW = numCols;
  localparam int IW = (numMasters > 1) ? $clog2(numMasters) : 1;
  localparam int PW = $clog2(maxOutstanding);
  localparam int OW = PW + 1;
  localparam logic [IW:0] NUM_M = (IW+1)'(numMasters);
  localparam logic [OW-1:0] FIFO_DEPTH = OW'(maxOutstanding);

  logic [IW-1:0]         rr_ptr_r;
  logic [IW-1:0]         id_mem_r [maxOutstanding];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [OW-1:0]         count_r;
  logic [numMasters-1:0] rd_valid_r;
  logic [DW-1:0]         rd_data_r;
  logic                  err_r;

  logic [numMasters-1:0] elig_s;
  logic [IW-1:0]         cand_s;
  logic                  grant_found_s;
  logic [IW-1:0]         grant_idx_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  handshake_s;
  logic                  push_s;
  logic                  pop_s;
  logic [IW-1:0]         head_id_s;

  // (a + b) mod numMasters for operands already below numMasters
  function automatic logic [IW-1:0] wrap_add_f(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= NUM_M) begin
      sum = sum - NUM_M;
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  function automatic logic [numMasters-1:0] onehot_f(input logic [IW-1:0] idx);
    logic [numMasters-1:0] vec;
    vec = '0;
    for (int m = 0; m < numMasters; m++) begin
      if (idx == IW'(m)) begin
        vec[m] = 1'b1;
      end else begin
        vec[m] = 1'b0;
      end
    end
    return vec;
  endfunction

  assign fifo_full_s  = (count_r == FIFO_DEPTH);
  assign fifo_empty_s = (count_r == {OW{1'b0}});
  assign head_id_s    = id_mem_r[rd_ptr_r];

  // Eligibility: fullness uses registered occupancy, so no pop bypass
  always_comb begin
    elig_s = '0;
    for (int m = 0; m < numMasters; m++) begin
      elig_s[m] = m_rq_valid_i[m] && (m_rq_wr_i[m] || !fifo_full_s);
    end
  end

  // Grant search; walk downward so the lowest offset wins
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int i = numMasters-1; i >= 0; i--) begin
      if (arbMode == 1) begin
        cand_s = IW'(i);
      end else begin
        cand_s = wrap_add_f(rr_ptr_r, IW'(i));
      end
      if (elig_s[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Slave request mux, zeroed when idle
  always_comb begin
    s_rq_valid_o = grant_found_s;
    if (grant_found_s) begin
      s_rq_wr_o   = m_rq_wr_i[grant_idx_s];
      s_wr_data_o = m_wr_data_i[grant_idx_s*DW +: DW];
      s_addr_o    = m_addr_i[grant_idx_s*AW +: AW];
    end else begin
      s_rq_wr_o   = 1'b0;
      s_wr_data_o = '0;
      s_addr_o    = '0;
    end
  end

  // Ready back to the granted master only
  always_comb begin
    if (grant_found_s && s_rq_ready_i) begin
      m_rq_ready_o = onehot_f(grant_idx_s);
    end else begin
      m_rq_ready_o = '0;
    end
  end

  assign handshake_s = s_rq_valid_o && s_rq_ready_i;
  assign push_s      = handshake_s && !s_rq_wr_o;
  assign pop_s       = s_rd_valid_i && !fifo_empty_s;

  // Round-robin pointer advances only on a handshake
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_r <= '0;
    end else if (handshake_s && (arbMode == 0)) begin
      rr_ptr_r <= wrap_add_f(grant_idx_s, IW'(1));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Read-ID FIFO storage and pointers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < maxOutstanding; k++) begin
        id_mem_r[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        id_mem_r[wr_ptr_r] <= grant_idx_s;
        wr_ptr_r           <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy: simultaneous push and pop cancel
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OW'(1);
        2'b01:   count_r <= count_r - OW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered response routing and sticky orphan-response error
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid_r <= '0;
      rd_data_r  <= '0;
      err_r      <= 1'b0;
    end else begin
      if (pop_s) begin
        rd_valid_r <= onehot_f(head_id_s);
        rd_data_r  <= s_rd_data_i;
      end else begin
        rd_valid_r <= '0;
        rd_data_r  <= rd_data_r;
      end
      err_r <= err_r | (s_rd_valid_i && fifo_empty_s);
    end
  end

  assign m_rd_valid_o  = rd_valid_r;
  assign m_rd_data_o   = rd_data_r;
  assign err_o         = err_r;
  assign outstanding_o = count_r;

endmodule
